// File: rtl/rv_fetch_pkg.sv
// Shared fetch-stage constants and the fetch-entry payload type.
package rv_fetch_pkg;

  localparam int unsigned FETCH_XLEN  = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [FETCH_XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifq_slot_ram.sv
// Fetch queue slot storage: pc written at allocation, instr at fill,
// asynchronous head read, plus a per-slot filled flag.
module ifq_slot_ram #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            pc_we,
  input  logic [AW-1:0]   pc_waddr,
  input  logic [XLEN-1:0] pc_wdata,
  input  logic            instr_we,
  input  logic [AW-1:0]   instr_waddr,
  input  logic [XLEN-1:0] instr_wdata,
  input  logic            free,
  input  logic [AW-1:0]   raddr,
  output logic [XLEN-1:0] rd_pc,
  output logic [XLEN-1:0] rd_instr,
  output logic            rd_filled
);

  logic [XLEN-1:0]  pc_mem    [DEPTH];
  logic [XLEN-1:0]  instr_mem [DEPTH];
  logic [DEPTH-1:0] filled;

  // Payload arrays carry no reset; validity lives in filled and the top's counters.
  always_ff @(posedge clk) begin
    if (pc_we)    pc_mem[pc_waddr]       <= pc_wdata;
    if (instr_we) instr_mem[instr_waddr] <= instr_wdata;
  end

  // A slot is filled at most once per allocation and released by the head pop.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      filled <= '0;
    end else begin
      if (instr_we) filled[instr_waddr] <= 1'b1;
      if (free)     filled[raddr]       <= 1'b0;
    end
  end

  assign rd_pc     = pc_mem[raddr];
  assign rd_instr  = instr_mem[raddr];
  assign rd_filled = filled[raddr];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: owns the sequential fetch PC, issues in-order
// word requests and buffers returned instructions with their PCs for decode.
module ifetch_queue
  import rv_fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [XLEN-1:0] fetch_pc, fetch_pc_d;
  logic [AW-1:0]   alloc_ptr, alloc_d, fill_ptr, fill_d, head_ptr, head_d;
  logic [CW-1:0]   count, count_d, pending, pending_d, drop_cnt, drop_d;
  logic            credit_ok, req_fire, rsp_drop, rsp_fill, pop, head_filled;

  // Allocated slots plus stale-response credits never exceed the slot count.
  assign credit_ok      = ((CW+1)'(count) + (CW+1)'(drop_cnt)) < (CW+1)'(DEPTH);
  assign imem_req_valid = rst_n & ~redirect_valid & credit_ok;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign rsp_drop = imem_rsp_valid & (drop_cnt != '0);
  assign rsp_fill = imem_rsp_valid & (drop_cnt == '0) & ~redirect_valid;

  assign out_valid = rst_n & ~redirect_valid & (count != '0) & head_filled;
  assign pop       = out_valid & out_ready;

  ifq_slot_ram #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_slots (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (redirect_valid),
    .pc_we       (req_fire),
    .pc_waddr    (alloc_ptr),
    .pc_wdata    (fetch_pc),
    .instr_we    (rsp_fill),
    .instr_waddr (fill_ptr),
    .instr_wdata (imem_rsp_data),
    .free        (pop),
    .raddr       (head_ptr),
    .rd_pc       (out_pc),
    .rd_instr    (out_instr),
    .rd_filled   (head_filled)
  );

  // Next-state for fetch PC, ring pointers and credit counters.
  always_comb begin
    fetch_pc_d = fetch_pc;
    alloc_d    = alloc_ptr;
    fill_d     = fill_ptr;
    head_d     = head_ptr;
    count_d    = count;
    pending_d  = pending;
    drop_d     = drop_cnt;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~XLEN'(INSTR_BYTES - 1);
      alloc_d    = '0;
      fill_d     = '0;
      head_d     = '0;
      count_d    = '0;
      pending_d  = '0;
      // Every outstanding request becomes stale; a response this cycle retires one.
      drop_d     = pending + drop_cnt - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc + XLEN'(INSTR_BYTES);
        alloc_d    = alloc_ptr + AW'(1);
      end
      if (rsp_drop) drop_d = drop_cnt - CW'(1);
      if (rsp_fill) fill_d = fill_ptr + AW'(1);
      if (pop)      head_d = head_ptr + AW'(1);
      count_d   = count + CW'(req_fire) - CW'(pop);
      pending_d = pending + CW'(req_fire) - CW'(rsp_fill);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc  <= RESET_PC;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      count     <= '0;
      pending   <= '0;
      drop_cnt  <= '0;
    end else begin
      fetch_pc  <= fetch_pc_d;
      alloc_ptr <= alloc_d;
      fill_ptr  <= fill_d;
      head_ptr  <= head_d;
      count     <= count_d;
      pending   <= pending_d;
      drop_cnt  <= drop_d;
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    ((CW+1)'(count) + (CW+1)'(drop_cnt)) <= (CW+1)'(DEPTH));
  a_pending_le_count : assert property (@(posedge clk) disable iff (!rst_n)
    pending <= count);
  a_rsp_has_credit : assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> ((pending != '0) || (drop_cnt != '0)));

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue against a queue-level reference model.
module tb_ifetch_queue;
  import rv_fetch_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0100;

  logic        clk, rst_n, redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_instr;

  ifetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { fetch_entry_t e; bit filled; } mentry_t;
  typedef struct { int due; logic [31:0] data; } mrsp_t;

  mentry_t     mq[$];
  mrsp_t       memq[$];
  int          stale, cyc, last_due, lat, lat_max, rdy_pct, ordy_pct;
  bit          lat_rand;
  logic [31:0] mpc;
  logic [31:0] req_log[$], out_log[$];
  int          first_ov;
  bit          ov_seen, rv_seen;
  logic [31:0] last_pc;
  int          tests_run, fails;

  function automatic logic [31:0] instr_of(logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ NOP_INSTR;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    req_log.delete();
    out_log.delete();
    first_ov = -1;
  endtask

  // One clock: drive inputs, check at negedge, advance the model across the edge.
  task automatic tick();
    bit          exp_rv, exp_ov, req_fire, pop;
    int          n_unfilled, d;
    logic [31:0] pc_now;
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    out_ready      = ($urandom_range(99) < ordy_pct);
    if (memq.size() != 0 && memq[0].due == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memq[0].data;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    @(negedge clk);
    exp_rv = rst_n && !redirect_valid && (mq.size() + stale < DEPTH);
    exp_ov = rst_n && !redirect_valid && mq.size() > 0 && mq[0].filled;
    chk("req_valid", imem_req_valid, exp_rv);
    if (exp_rv) chk("req_addr", imem_req_addr, mpc);
    chk("out_valid", out_valid, exp_ov);
    if (exp_ov) begin
      chk("out_pc", out_pc, mq[0].e.pc);
      chk("out_instr", out_instr, mq[0].e.instr);
    end
    ov_seen = out_valid;
    rv_seen = imem_req_valid;
    last_pc = out_pc;
    if (imem_req_valid && imem_req_ready) req_log.push_back(imem_req_addr);
    if (out_valid && out_ready) out_log.push_back(out_pc);
    if (out_valid && first_ov < 0) first_ov = cyc;
    req_fire = exp_rv && imem_req_ready;
    pop      = exp_ov && out_ready;
    pc_now   = mpc;
    if (!rst_n) begin
      mq.delete();
      stale = 0;
      mpc   = RPC;
    end else if (redirect_valid) begin
      n_unfilled = 0;
      foreach (mq[i]) if (!mq[i].filled) n_unfilled++;
      stale = n_unfilled + stale - (imem_rsp_valid ? 1 : 0);
      mq.delete();
      mpc = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (imem_rsp_valid) begin
        if (stale > 0) stale--;
        else begin
          for (int i = 0; i < mq.size(); i++) begin
            if (!mq[i].filled) begin
              mq[i].filled  = 1'b1;
              mq[i].e.instr = imem_rsp_data;
              break;
            end
          end
        end
      end
      if (pop) void'(mq.pop_front());
      if (req_fire) begin
        mq.push_back('{e: '{pc: mpc, instr: 32'h0}, filled: 1'b0});
        mpc = mpc + 32'd4;
      end
    end
    // Memory side: in-order responses, latency >= 1, reset together with the DUT.
    if (imem_rsp_valid) void'(memq.pop_front());
    if (!rst_n) begin
      memq.delete();
      last_due = cyc;
    end else if (req_fire) begin
      d = cyc + (lat_rand ? int'($urandom_range(lat_max, 1)) : lat);
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      memq.push_back('{due: d, data: instr_of(pc_now)});
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic redirect_to(logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int rel;
    tests_run = 0; fails = 0; cyc = 0; last_due = 0; stale = 0; mpc = RPC;
    lat = 1; lat_max = 4; lat_rand = 1'b0; rdy_pct = 100; ordy_pct = 100;
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; out_ready = 1'b0;
    clear_logs();
    @(posedge clk);
    #1;
    repeat (2) tick();

    // Reset release streaming at latency 1
    rst_n = 1'b1;
    rel = cyc;
    repeat (10) tick();
    chk("p1_req0", req_log[0], 32'h100);
    chk("p1_req1", req_log[1], 32'h104);
    chk("p1_req2", req_log[2], 32'h108);
    chk("p1_ov_latency", 32'(first_ov - rel), 32'd2);
    chk("p1_out0", out_log[0], 32'h100);
    chk("p1_out1", out_log[1], 32'h104);
    chk("p1_pops", 32'(out_log.size()), 32'd8);

    // Decode stalled: fills exactly DEPTH slots then stops requesting
    ordy_pct = 0;
    redirect_to(32'h0);
    clear_logs();
    repeat (8) tick();
    chk("p2_req_count", 32'(req_log.size()), 32'd4);
    chk("p2_req0", req_log[0], 32'h0);
    chk("p2_req3", req_log[3], 32'hC);
    chk("p2_hold_valid", 32'(ov_seen), 32'd1);
    chk("p2_hold_pc", last_pc, 32'h0);
    clear_logs();
    ordy_pct = 100;
    repeat (6) tick();
    chk("p2_refill_reqs", 32'(req_log.size()), 32'd5);
    chk("p2_refill_pops", 32'(out_log.size()), 32'd6);

    // Redirect with two requests in flight at latency 3
    redirect_to(32'h1000);
    lat = 3;
    repeat (2) tick();
    redirect_to(32'h2002);
    clear_logs();
    repeat (12) tick();
    chk("p3_first_req", req_log[0], 32'h2000);
    chk("p3_first_out", out_log[0], 32'h2000);

    // Redirect coinciding with a response and a pop
    lat = 1;
    repeat (6) tick();
    redirect_to(32'h3000);
    chk("p4_redirect_ov", 32'(ov_seen), 32'd0);
    clear_logs();
    repeat (6) tick();
    chk("p4_first_out", out_log[0], 32'h3000);

    // Address wrap at the top of the address space
    redirect_to(32'hFFFF_FFF8);
    clear_logs();
    repeat (8) tick();
    chk("p5_req0", req_log[0], 32'hFFFF_FFF8);
    chk("p5_req1", req_log[1], 32'hFFFF_FFFC);
    chk("p5_req2", req_log[2], 32'h0000_0000);
    chk("p5_out2", out_log[2], 32'h0000_0000);

    // Mid-stream reset with three slots full
    ordy_pct = 0;
    redirect_to(32'h40);
    repeat (3) tick();
    rdy_pct = 0;
    repeat (2) tick();
    chk("p6_prefull_valid", 32'(ov_seen), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("p6_rst_req_valid", 32'(rv_seen), 32'd0);
    chk("p6_rst_out_valid", 32'(ov_seen), 32'd0);
    rst_n = 1'b1;
    rdy_pct = 100;
    ordy_pct = 100;
    clear_logs();
    tick();
    chk("p6_post_out_valid", 32'(ov_seen), 32'd0);
    repeat (3) tick();
    chk("p6_restart_pc", req_log[0], RPC);

    // Randomized traffic with redirects and occasional resets
    lat_rand = 1'b1;
    for (int k = 0; k < 600; k++) begin
      if (k % 50 == 0) begin
        rdy_pct  = int'($urandom_range(100, 30));
        ordy_pct = int'($urandom_range(100, 20));
      end
      rst_n          = ($urandom_range(199) != 0);
      redirect_valid = ($urandom_range(99) < 4);
      redirect_pc    = $urandom;
      tick();
    end
    rst_n = 1'b1;
    redirect_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
